// File: rtl/int_reservation_station.sv
// Integer ALU reservation station: buffers dispatched ops, snoops the CDB for operand
// wakeup, issues the lowest-index ready entry, and kills speculative entries on a flush.
module int_reservation_station #(
  parameter int unsigned NUM_ENTRY         = 4,
  parameter int unsigned BW_TAG            = 4,
  parameter int unsigned BW_PROCESSOR_DATA = 32,
  parameter int unsigned BW_OPCODE_INT     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_iq_valid,
  output logic                           i_iq_ready,
  input  logic [BW_OPCODE_INT-1:0]       i_iq_opcode,
  input  logic [2*BW_TAG-1:0]            i_iq_Q_flatten,
  input  logic [2*BW_PROCESSOR_DATA-1:0] i_iq_V_flatten,
  input  logic [BW_TAG-1:0]              i_iq_tag,
  input  logic                           i_iq_speculation,
  input  logic                           i_cdb_valid,
  input  logic [BW_TAG-1:0]              i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]   i_cdb_data,
  input  logic                           i_branch_valid,
  input  logic                           i_branch_flush,
  output logic                           o_alu_valid,
  input  logic                           o_alu_ready,
  output logic [BW_OPCODE_INT-1:0]       o_alu_opcode,
  output logic [BW_PROCESSOR_DATA-1:0]   o_alu_a,
  output logic [BW_PROCESSOR_DATA-1:0]   o_alu_b,
  output logic [BW_TAG-1:0]              o_alu_tag
);

  localparam int unsigned BW_IDX = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

  logic [NUM_ENTRY-1:0]                   r_busy, r_spec;
  logic [BW_OPCODE_INT-1:0]               r_opcode [NUM_ENTRY];
  logic [BW_TAG-1:0]                      r_tag    [NUM_ENTRY];
  logic [1:0][BW_TAG-1:0]                 r_q      [NUM_ENTRY];
  logic [1:0][BW_PROCESSOR_DATA-1:0]      r_v      [NUM_ENTRY];

  logic [NUM_ENTRY-1:0]                   w_busy_nxt, w_spec_nxt;
  logic [BW_OPCODE_INT-1:0]               w_opcode_nxt [NUM_ENTRY];
  logic [BW_TAG-1:0]                      w_tag_nxt    [NUM_ENTRY];
  logic [1:0][BW_TAG-1:0]                 w_q_nxt      [NUM_ENTRY];
  logic [1:0][BW_PROCESSOR_DATA-1:0]      w_v_nxt      [NUM_ENTRY];

  logic              w_alloc_found, w_sel_found;
  logic [BW_IDX-1:0] w_alloc_idx, w_sel_idx;
  logic              w_flush, w_resolve, w_issue, w_dispatch, w_cdb_hit;
  logic [BW_TAG-1:0] w_in_q;

  assign w_flush    = i_branch_valid & i_branch_flush;
  assign w_resolve  = i_branch_valid & ~i_branch_flush;
  assign w_cdb_hit  = i_cdb_valid & (i_cdb_tag != '0);
  assign w_dispatch = i_iq_valid & i_iq_ready;
  assign w_issue    = o_alu_valid & o_alu_ready;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    w_sel_found   = 1'b0;
    w_sel_idx     = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = BW_IDX'(i);
      end
      if (r_busy[i] && r_q[i][0] == '0 && r_q[i][1] == '0) begin
        w_sel_found = 1'b1;
        w_sel_idx   = BW_IDX'(i);
      end
    end
  end

  assign i_iq_ready   = w_alloc_found;
  assign o_alu_valid  = w_sel_found & ~(w_flush & r_spec[w_sel_idx]);
  assign o_alu_opcode = w_sel_found ? r_opcode[w_sel_idx] : '0;
  assign o_alu_a      = w_sel_found ? r_v[w_sel_idx][0] : '0;
  assign o_alu_b      = w_sel_found ? r_v[w_sel_idx][1] : '0;
  assign o_alu_tag    = w_sel_found ? r_tag[w_sel_idx] : '0;

  always_comb begin
    w_busy_nxt   = r_busy;
    w_spec_nxt   = r_spec;
    w_opcode_nxt = r_opcode;
    w_tag_nxt    = r_tag;
    w_q_nxt      = r_q;
    w_v_nxt      = r_v;
    w_in_q       = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (w_cdb_hit && r_q[i][k] == i_cdb_tag) begin
          w_q_nxt[i][k] = '0;
          w_v_nxt[i][k] = i_cdb_data;
        end
      end
      if (w_issue && w_sel_idx == BW_IDX'(i)) w_busy_nxt[i] = 1'b0;
      if (w_flush && r_spec[i])               w_busy_nxt[i] = 1'b0;
      if (w_resolve)                          w_spec_nxt[i] = 1'b0;
    end
    // A speculative op dispatched during a flush completes its handshake but is dropped.
    if (w_dispatch && !(w_flush && i_iq_speculation)) begin
      w_busy_nxt[w_alloc_idx]   = 1'b1;
      w_spec_nxt[w_alloc_idx]   = i_iq_speculation & ~i_branch_valid;
      w_opcode_nxt[w_alloc_idx] = i_iq_opcode;
      w_tag_nxt[w_alloc_idx]    = i_iq_tag;
      for (int k = 0; k < 2; k++) begin
        w_in_q = i_iq_Q_flatten[k*BW_TAG +: BW_TAG];
        if (w_cdb_hit && w_in_q == i_cdb_tag) begin
          w_q_nxt[w_alloc_idx][k] = '0;
          w_v_nxt[w_alloc_idx][k] = i_cdb_data;
        end else begin
          w_q_nxt[w_alloc_idx][k] = w_in_q;
          w_v_nxt[w_alloc_idx][k] = i_iq_V_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_spec <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        r_opcode[i] <= '0;
        r_tag[i]    <= '0;
        r_q[i]      <= '0;
        r_v[i]      <= '0;
      end
    end else begin
      r_busy   <= w_busy_nxt;
      r_spec   <= w_spec_nxt;
      r_opcode <= w_opcode_nxt;
      r_tag    <= w_tag_nxt;
      r_q      <= w_q_nxt;
      r_v      <= w_v_nxt;
    end
  end

endmodule

// File: tb/tb_int_reservation_station.sv
// Directed table-driven bench for int_reservation_station: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_int_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_iq_valid, i_iq_ready, i_iq_speculation;
  logic [3:0]  i_iq_opcode, i_iq_tag;
  logic [7:0]  i_iq_Q_flatten;
  logic [63:0] i_iq_V_flatten;
  logic        i_cdb_valid;
  logic [3:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        i_branch_valid, i_branch_flush;
  logic        o_alu_valid, o_alu_ready;
  logic [3:0]  o_alu_opcode, o_alu_tag;
  logic [31:0] o_alu_a, o_alu_b;

  always #5 clk = ~clk;

  int_reservation_station dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_iq_valid       (i_iq_valid),
    .i_iq_ready       (i_iq_ready),
    .i_iq_opcode      (i_iq_opcode),
    .i_iq_Q_flatten   (i_iq_Q_flatten),
    .i_iq_V_flatten   (i_iq_V_flatten),
    .i_iq_tag         (i_iq_tag),
    .i_iq_speculation (i_iq_speculation),
    .i_cdb_valid      (i_cdb_valid),
    .i_cdb_tag        (i_cdb_tag),
    .i_cdb_data       (i_cdb_data),
    .i_branch_valid   (i_branch_valid),
    .i_branch_flush   (i_branch_flush),
    .o_alu_valid      (o_alu_valid),
    .o_alu_ready      (o_alu_ready),
    .o_alu_opcode     (o_alu_opcode),
    .o_alu_a          (o_alu_a),
    .o_alu_b          (o_alu_b),
    .o_alu_tag        (o_alu_tag)
  );

  typedef struct {
    logic        iq_valid;
    logic [3:0]  op, q0, q1, tag;
    logic [31:0] v0, v1;
    logic        spec;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        br_valid, br_flush, alu_ready;
    logic        e_rdy, e_vld;
    logic [3:0]  e_op, e_tag;
    logic [31:0] e_a, e_b;
  } vec_t;

  vec_t cur;
  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] q0, input logic [3:0] q1,
                      input logic [31:0] v0, input logic [31:0] v1, input logic [3:0] tag,
                      input logic spec);
    cur.iq_valid = 1'b1; cur.op = op; cur.q0 = q0; cur.q1 = q1;
    cur.v0 = v0; cur.v1 = v1; cur.tag = tag; cur.spec = spec;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cur.cdb_valid = 1'b1; cur.cdb_tag = t; cur.cdb_data = d;
  endtask

  task automatic br(input logic flush);
    cur.br_valid = 1'b1; cur.br_flush = flush;
  endtask

  task automatic ar();
    cur.alu_ready = 1'b1;
  endtask

  task automatic row(input logic rdy, input logic vld, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    cur.e_rdy = rdy; cur.e_vld = vld; cur.e_op = op; cur.e_a = a; cur.e_b = b; cur.e_tag = tag;
    vq.push_back(cur);
    cur = '{default: '0};
  endtask

  task automatic drive(input vec_t v);
    i_iq_valid       = v.iq_valid;
    i_iq_opcode      = v.op;
    i_iq_Q_flatten   = {v.q1, v.q0};
    i_iq_V_flatten   = {v.v1, v.v0};
    i_iq_tag         = v.tag;
    i_iq_speculation = v.spec;
    i_cdb_valid      = v.cdb_valid;
    i_cdb_tag        = v.cdb_tag;
    i_cdb_data       = v.cdb_data;
    i_branch_valid   = v.br_valid;
    i_branch_flush   = v.br_flush;
    o_alu_ready      = v.alu_ready;
  endtask

  initial begin
    cur = '{default: '0};
    drive(cur);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", {31'd0, o_alu_valid}, 32'd0);
    check("reset_iq_ready", {31'd0, i_iq_ready}, 32'd1);
    check("reset_opcode", {28'd0, o_alu_opcode}, 32'd0);
    check("reset_a", o_alu_a, 32'd0);
    check("reset_b", o_alu_b, 32'd0);
    check("reset_tag", {28'd0, o_alu_tag}, 32'd0);
    rst_n = 1'b1;

    // Ready dispatch, issue next cycle
    disp(4'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 1'b0); ar(); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'd1, 32'd5, 32'd7, 4'd3);
    row(1, 0, 0, 0, 0, 0);
    // CDB wakeup of src0, later wakeup
    disp(4'd2, 4'd2, 4'd0, 32'hdead, 32'd9, 4'd4, 1'b0); ar(); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 0, 0, 0, 0, 0);
    cdb(4'd2, 32'h11); ar(); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'd2, 32'h11, 32'd9, 4'd4);
    // Same-cycle bypass on dispatch
    disp(4'd3, 4'd2, 4'd0, 32'h0, 32'd9, 4'd7, 1'b0); cdb(4'd2, 32'h11); ar();
    row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'd3, 32'h11, 32'd9, 4'd7);
    row(1, 0, 0, 0, 0, 0);
    // Both operands wake on one broadcast
    disp(4'd4, 4'd8, 4'd8, 32'h1, 32'h2, 4'd5, 1'b0); row(1, 0, 0, 0, 0, 0);
    cdb(4'd8, 32'haa); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'd4, 32'haa, 32'haa, 4'd5);
    row(1, 0, 0, 0, 0, 0);
    // CDB tag 0 never overwrites an operand
    disp(4'd5, 4'd0, 4'd0, 32'd1, 32'd2, 4'd6, 1'b0); cdb(4'd0, 32'hff); row(1, 0, 0, 0, 0, 0);
    cdb(4'd0, 32'hff); ar(); row(1, 1, 4'd5, 32'd1, 32'd2, 4'd6);
    row(1, 0, 0, 0, 0, 0);
    // Fill all four entries waiting on tag 6, then backpressure and drain in order
    for (int i = 1; i <= 4; i++) begin
      disp(4'd6, 4'd6, 4'd0, 32'h0, 32'h10 + i, 4'(i), 1'b0); row(1, 0, 0, 0, 0, 0);
    end
    disp(4'd9, 4'd0, 4'd0, 32'h0, 32'h0, 4'd9, 1'b0); row(0, 0, 0, 0, 0, 0);
    cdb(4'd6, 32'h66); row(0, 0, 0, 0, 0, 0);
    row(0, 1, 4'd6, 32'h66, 32'h11, 4'd1);
    row(0, 1, 4'd6, 32'h66, 32'h11, 4'd1);
    ar(); row(0, 1, 4'd6, 32'h66, 32'h11, 4'd1);
    ar(); row(1, 1, 4'd6, 32'h66, 32'h12, 4'd2);
    ar(); row(1, 1, 4'd6, 32'h66, 32'h13, 4'd3);
    ar(); row(1, 1, 4'd6, 32'h66, 32'h14, 4'd4);
    row(1, 0, 0, 0, 0, 0);
    // Flush: speculative entries and a same-cycle speculative dispatch vanish
    disp(4'd7, 4'd0, 4'd0, 32'd1, 32'd2, 4'd1, 1'b0); row(1, 0, 0, 0, 0, 0);
    disp(4'd7, 4'd0, 4'd0, 32'd3, 32'd4, 4'd2, 1'b1); row(1, 1, 4'd7, 32'd1, 32'd2, 4'd1);
    disp(4'd7, 4'ha, 4'd0, 32'd0, 32'd6, 4'd3, 1'b1); row(1, 1, 4'd7, 32'd1, 32'd2, 4'd1);
    disp(4'd8, 4'd0, 4'd0, 32'd9, 32'd9, 4'd9, 1'b1); br(1'b1);
    row(1, 1, 4'd7, 32'd1, 32'd2, 4'd1);
    ar(); row(1, 1, 4'd7, 32'd1, 32'd2, 4'd1);
    cdb(4'ha, 32'h55); ar(); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 0, 0, 0, 0, 0);
    // A selected speculative entry is not issued during the flush cycle
    disp(4'd9, 4'd0, 4'd0, 32'hc, 32'hd, 4'hc, 1'b1); row(1, 0, 0, 0, 0, 0);
    br(1'b1); ar(); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 0, 0, 0, 0, 0);
    // Correct resolve protects the entry from a later flush
    disp(4'ha, 4'hb, 4'd0, 32'd0, 32'h77, 4'hd, 1'b1); row(1, 0, 0, 0, 0, 0);
    br(1'b0); row(1, 0, 0, 0, 0, 0);
    br(1'b1); row(1, 0, 0, 0, 0, 0);
    cdb(4'hb, 32'h33); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'ha, 32'h33, 32'h77, 4'hd);
    row(1, 0, 0, 0, 0, 0);
    // Dispatch in the resolve cycle is written non-speculative
    disp(4'hb, 4'he, 4'd0, 32'd0, 32'h88, 4'he, 1'b1); br(1'b0); row(1, 0, 0, 0, 0, 0);
    br(1'b1); row(1, 0, 0, 0, 0, 0);
    cdb(4'he, 32'h44); row(1, 0, 0, 0, 0, 0);
    ar(); row(1, 1, 4'hb, 32'h44, 32'h88, 4'he);
    row(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("row%0d_iq_ready", i), {31'd0, i_iq_ready}, {31'd0, vq[i].e_rdy});
      check($sformatf("row%0d_valid", i), {31'd0, o_alu_valid}, {31'd0, vq[i].e_vld});
      if (vq[i].e_vld) begin
        check($sformatf("row%0d_opcode", i), {28'd0, o_alu_opcode}, {28'd0, vq[i].e_op});
        check($sformatf("row%0d_a", i), o_alu_a, vq[i].e_a);
        check($sformatf("row%0d_b", i), o_alu_b, vq[i].e_b);
        check($sformatf("row%0d_tag", i), {28'd0, o_alu_tag}, {28'd0, vq[i].e_tag});
      end
    end

    // Asynchronous reset with three busy ready entries
    cur = '{default: '0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      disp(4'h3, 4'd0, 4'd0, 32'h100 + i, 32'h200 + i, 4'(i + 1), 1'b0);
      drive(cur);
      cur = '{default: '0};
    end
    @(negedge clk);
    drive(cur);
    #1;
    check("prereset_valid", {31'd0, o_alu_valid}, 32'd1);
    check("prereset_tag", {28'd0, o_alu_tag}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, o_alu_valid}, 32'd0);
    check("async_reset_iq_ready", {31'd0, i_iq_ready}, 32'd1);
    check("async_reset_tag", {28'd0, o_alu_tag}, 32'd0);
    check("async_reset_a", o_alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    o_alu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_reset_valid%0d", i), {31'd0, o_alu_valid}, 32'd0);
      check($sformatf("post_reset_iq_ready%0d", i), {31'd0, i_iq_ready}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_reservation_station.md
Name: int_reservation_station

Overview:
- Reservation station for the integer ALU; sits directly downstream of the instruction queue's int issue port.
- Buffers up to NUM_ENTRY dispatched integer ops.
- Snoops the common data bus (CDB) to resolve pending source tags.
- Issues ready ops to the integer ALU over a valid/ready handshake.
- Kills speculative entries on branch misprediction and clears speculation on a correct resolve.

Parameters:
- NUM_ENTRY, 4, number of station entries (≥2).
- BW_TAG, 4, rename-tag width; tag 0 means "value present, no producer".
- BW_PROCESSOR_DATA, 32, operand width.
- BW_OPCODE_INT, 4, integer opcode width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_iq_valid  input  1  dispatch valid
- i_iq_ready  output  1  station can accept a dispatch
- i_iq_opcode  input  BW_OPCODE_INT  ALU opcode
- i_iq_Q_flatten  input  2*BW_TAG  source tags; src0 in low bits
- i_iq_V_flatten  input  2*BW_PROCESSOR_DATA  source values; src0 in low bits; meaningful when the tag is 0
- i_iq_tag  input  BW_TAG  destination tag, nonzero
- i_iq_speculation  input  1  op lies behind an unresolved branch
- i_cdb_valid  input  1  CDB broadcast valid
- i_cdb_tag  input  BW_TAG  broadcast tag
- i_cdb_data  input  BW_PROCESSOR_DATA  broadcast value
- i_branch_valid  input  1  branch resolved this cycle
- i_branch_flush  input  1  with i_branch_valid: mispredicted
- o_alu_valid  output  1  issue valid
- o_alu_ready  input  1  ALU accepts
- o_alu_opcode  output  BW_OPCODE_INT  issued opcode
- o_alu_a  output  BW_PROCESSOR_DATA  src0 value
- o_alu_b  output  BW_PROCESSOR_DATA  src1 value
- o_alu_tag  output  BW_TAG  issued destination tag

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset clears all entry busy bits, tags, values and speculation bits to 0. After reset, o_alu_valid=0, o_alu_opcode/a/b/tag=0, i_iq_ready=1.
- Entry state: busy, spec, opcode, dest tag, and Q[2]/V[2].
- i_iq_ready = any entry not busy, evaluated on registered state. An entry freed this cycle is not reusable until next cycle.
- Dispatch: on i_iq_valid && i_iq_ready, write the lowest-index free entry at the clock edge.
- Same-cycle CDB bypass on dispatch: if i_cdb_valid and an incoming Q[k] equals i_cdb_tag (nonzero), store Q[k]=0 and V[k]=i_cdb_data.
- Wakeup: every cycle, for each busy entry and k in {0,1}, if Q[k]!=0 and i_cdb_valid and Q[k]==i_cdb_tag, set Q[k]<=0 and V[k]<=i_cdb_data.
  - A CDB tag of 0 is ignored.
  - Both operands may wake in the same cycle.
- Ready condition: an entry is ready when busy && Q[0]==0 && Q[1]==0, using registered state. An entry woken this cycle is issuable next cycle, so minimum dispatch-to-issue latency is 1 cycle.
- Select: among ready entries, pick the lowest index.
  - o_alu_* are combinational from the selected entry.
  - o_alu_valid = a ready entry exists && !(kill of that entry this cycle).
- Issue: o_alu_valid && o_alu_ready frees the selected entry at the clock edge.
  - If o_alu_ready=0, the selection and outputs hold stable unless a lower-index entry becomes ready; valid is never dropped except by a flush.
- Speculation: only one unresolved branch exists at a time (guaranteed upstream).
- Flush (i_branch_valid && i_branch_flush):
  - Clear busy on every entry with spec=1.
  - A same-cycle dispatch with i_iq_speculation=1 is accepted (handshake completes) and discarded.
  - A speculative selected entry is not issued: o_alu_valid is forced 0 that cycle.
  - Non-speculative entries are unaffected.
- Correct resolve (i_branch_valid && !i_branch_flush): clear spec on all entries, and write spec=0 for a same-cycle dispatch.
- Simultaneous events in one cycle: dispatch + wakeup + issue + branch resolve all apply together. Kill takes priority over wakeup for the same entry.
- Full: all entries busy → i_iq_ready=0; the IQ stalls.
- Empty: o_alu_valid=0.
- Reset mid-operation drops all entries immediately and asynchronously.

Test Plan:
- Ready dispatch: dispatch opcode=ADD, Q=0/0, V=5/7, tag=3 → next cycle o_alu_valid=1, a=5, b=7, tag=3. With o_alu_ready=1 the entry frees and o_alu_valid=0 the following cycle.
- CDB wakeup: dispatch Q0=2, Q1=0, V1=9, tag=4. Hold o_alu_valid=0. CDB tag=2, data=0x11 → next cycle issue a=0x11, b=9. Repeat with the CDB in the same cycle as dispatch → issue 1 cycle after dispatch.
- Full and backpressure: fill 4 entries all waiting on tag 6 → i_iq_ready=0. Broadcast tag 6 with o_alu_ready=0 → o_alu_valid=1 on entry 0, outputs stable. Then raise ready → 4 issues in index order over 4 cycles; i_iq_ready=1 after the first issue.
- Flush: entries {tag1 spec=0 ready, tag2 spec=1 ready, tag3 spec=1 waiting}; flush pulse → tags 2 and 3 never issue, tag1 issues. A same-cycle spec=1 dispatch is accepted and never appears.
- Correct resolve: spec=1 entry waiting; correct resolve, then a later flush → the entry survives and issues after its wakeup.
- Async reset mid-stream: assert rst_n low with 3 busy entries → o_alu_valid=0 and i_iq_ready=1 immediately; no stale issue after release.
